dtw_bt_sched: RTL and testbench

//  Job sequencer for one DTW match: streams template frame indices into the PE array,

---
 rtl/dtw_pkg.sv | 14 +
 rtl/dtw_wr_fifo.sv | 59 +++++
 rtl/dtw_bt_sched.sv | 162 ++++++++++++++++
 tb/tb_dtw_bt_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared state encoding and widths for the DTW backtrack job sequencer
package dtw_pkg;

    localparam int DTW_IDX_W  = 5;
    localparam int DTW_WORD_W = 32;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FEED   = 3'd1;
    localparam logic [2:0] S_WAIT_D = 3'd2;
    localparam logic [2:0] S_BT     = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/dtw_wr_fifo.sv
// rtl/dtw_wr_fifo.sv - single-clock write buffer between backtrack words and the SRAM port
module dtw_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A push into a full buffer is still taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dtw_bt_sched.sv
// rtl/dtw_bt_sched.sv - DTW job sequencer: template feed, score wait, backtrack launch, SRAM write-out
module dtw_bt_sched
    import dtw_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DTW_IDX_W-1:0]  i_tlen,
    input  logic [ADDR_W-1:0]     i_base_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [ADDR_W-1:0]     o_word_cnt,
    output logic                  o_feed_valid,
    output logic [DTW_IDX_W-1:0]  o_feed_tidx,
    input  logic                  i_last_outena,
    output logic                  o_bt_start,
    input  logic                  i_bt_valid,
    input  logic [DTW_WORD_W-1:0] i_bt_data,
    input  logic                  i_bt_end,
    output logic                  o_sram_we,
    output logic [ADDR_W-1:0]     o_sram_addr,
    output logic [DTW_WORD_W-1:0] o_sram_wdata,
    input  logic                  i_sram_ready
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [DTW_IDX_W-1:0]  tlen_q;
    logic [ADDR_W-1:0]     base_q;
    logic [DTW_IDX_W-1:0]  feed_cnt;
    logic [7:0]            wait_cnt;
    logic                  bt_first;
    logic                  err_q;
    logic [ADDR_W-1:0]     word_cnt;

    logic                  start_acc;
    logic                  timeout_hit;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_drop;
    logic [DTW_WORD_W-1:0] fifo_head;

    assign start_acc   = (state == S_IDLE) && i_start;
    // Timeout fires on the edge where the wait counter would reach TIMEOUT.
    assign timeout_hit = (state == S_WAIT_D) && !i_last_outena && (wait_cnt == WAIT_LAST);
    assign fifo_push   = (state == S_BT) && i_bt_valid;
    assign fifo_pop    = !fifo_empty && i_sram_ready;
    assign fifo_drop   = fifo_push && fifo_full && !fifo_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_tlen == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                if (feed_cnt == tlen_q - 1'b1) begin
                    state_nxt = S_WAIT_D;
                end
            end
            S_WAIT_D: begin
                if (i_last_outena) begin
                    state_nxt = S_BT;
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_BT: begin
                if (i_bt_end) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (state != S_IDLE);
        o_done       = (state == S_DONE);
        o_feed_valid = (state == S_FEED);
        o_feed_tidx  = (state == S_FEED) ? feed_cnt : '0;
        o_bt_start   = (state == S_BT) && bt_first;
        o_err        = err_q;
        o_word_cnt   = word_cnt;
        o_sram_we    = !fifo_empty;
        o_sram_addr  = base_q + word_cnt;
        o_sram_wdata = fifo_empty ? '0 : fifo_head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlen_q   <= '0;
            base_q   <= '0;
            feed_cnt <= '0;
            wait_cnt <= '0;
            bt_first <= 1'b0;
            err_q    <= 1'b0;
            word_cnt <= '0;
        end else begin
            // Only the cycle leaving WAIT_D marks the first BT cycle.
            bt_first <= (state == S_WAIT_D);
            wait_cnt <= (state == S_WAIT_D) ? wait_cnt + 1'b1 : 8'd0;
            if (start_acc) begin
                tlen_q   <= i_tlen;
                base_q   <= i_base_addr;
                feed_cnt <= '0;
                err_q    <= (i_tlen == '0);
                word_cnt <= '0;
            end else begin
                if (state == S_FEED) begin
                    feed_cnt <= feed_cnt + 1'b1;
                end
                if (timeout_hit || fifo_drop) begin
                    err_q <= 1'b1;
                end
                if (fifo_pop) begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    dtw_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DTW_WORD_W)
    ) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (i_bt_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_dtw_bt_sched.sv
// tb/tb_dtw_bt_sched.sv - directed self-checking bench for dtw_bt_sched
module tb_dtw_bt_sched;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic [4:0]        i_tlen = '0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [ADDR_W-1:0] o_word_cnt;
    logic              o_feed_valid;
    logic [4:0]        o_feed_tidx;
    logic              i_last_outena = 1'b0;
    logic              o_bt_start;
    logic              i_bt_valid = 1'b0;
    logic [31:0]       i_bt_data = '0;
    logic              i_bt_end = 1'b0;
    logic              o_sram_we;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [31:0]       o_sram_wdata;
    logic              i_sram_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    int                feed_q[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                bt_cnt = 0;
    int                done_cnt = 0;

    dtw_bt_sched #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (4),
        .TIMEOUT    (255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_tlen        (i_tlen),
        .i_base_addr   (i_base_addr),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_word_cnt    (o_word_cnt),
        .o_feed_valid  (o_feed_valid),
        .o_feed_tidx   (o_feed_tidx),
        .i_last_outena (i_last_outena),
        .o_bt_start    (o_bt_start),
        .i_bt_valid    (i_bt_valid),
        .i_bt_data     (i_bt_data),
        .i_bt_end      (i_bt_end),
        .o_sram_we     (o_sram_we),
        .o_sram_addr   (o_sram_addr),
        .o_sram_wdata  (o_sram_wdata),
        .i_sram_ready  (i_sram_ready)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: records what the DUT presents before each rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_feed_valid) feed_q.push_back(int'(o_feed_tidx));
            if (o_bt_start) bt_cnt++;
            if (o_done) done_cnt++;
            if (o_sram_we && i_sram_ready) begin
                wa_q.push_back(o_sram_addr);
                wd_q.push_back(o_sram_wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        feed_q.delete();
        wa_q.delete();
        wd_q.delete();
        bt_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(o_busy), 0);
        check({tag, "_done"},  32'(o_done), 0);
        check({tag, "_err"},   32'(o_err), 0);
        check({tag, "_wcnt"},  32'(o_word_cnt), 0);
        check({tag, "_fval"},  32'(o_feed_valid), 0);
        check({tag, "_tidx"},  32'(o_feed_tidx), 0);
        check({tag, "_btst"},  32'(o_bt_start), 0);
        check({tag, "_we"},    32'(o_sram_we), 0);
        check({tag, "_addr"},  32'(o_sram_addr), 0);
        check({tag, "_wdata"}, o_sram_wdata, 0);
    endtask

    task automatic start_job(input logic [4:0] tlen, input logic [ADDR_W-1:0] base);
        i_start = 1'b1;
        i_tlen = tlen;
        i_base_addr = base;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_to_bt(input logic [4:0] tlen, input logic [ADDR_W-1:0] base, input int dly);
        start_job(tlen, base);
        repeat (int'(tlen)) tick();
        repeat (dly) tick();
        i_last_outena = 1'b1;
        tick();
        i_last_outena = 1'b0;
    endtask

    task automatic send_bt(input int n, input int lo_s, input int lo_n, input logic [31:0] dbase);
        for (int k = 0; k < n; k++) begin
            i_bt_valid = 1'b1;
            i_bt_data = dbase + 32'(k);
            i_bt_end = (k == n - 1);
            i_sram_ready = !(k >= lo_s && k < lo_s + lo_n);
            tick();
        end
        i_bt_valid = 1'b0;
        i_bt_end = 1'b0;
        i_bt_data = '0;
        i_sram_ready = 1'b1;
    endtask

    task automatic wait_done(input int limit, output int c_out);
        c_out = -1;
        for (int c = 1; c <= limit; c++) begin
            tick();
            if (o_done) begin
                c_out = c;
                break;
            end
        end
    endtask

    task automatic check_writes(input string tag, input int n, input logic [ADDR_W-1:0] base,
                                input logic [31:0] dbase);
        logic [ADDR_W-1:0] ea;
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'(n));
        for (int k = 0; k < n && k < wa_q.size(); k++) begin
            ea = base + ADDR_W'(k);
            check($sformatf("%s_addr%0d", tag, k), 32'(wa_q[k]), 32'(ea));
            check($sformatf("%s_data%0d", tag, k), wd_q[k], dbase + 32'(k));
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_idle_outputs("rst");
        rst = 1'b0;
        tick();

        // 1: nominal job
        clear_mon();
        run_to_bt(5'd6, 10'h010, 3);
        check("t1_bt_start", 32'(o_bt_start), 1);
        check("t1_busy", 32'(o_busy), 1);
        send_bt(5, 0, 0, 32'hA100_0000);
        wait_done(20, cyc);
        check("t1_done_cyc", 32'(cyc), 2);
        check("t1_nfeed", 32'(feed_q.size()), 6);
        for (int k = 0; k < 6 && k < feed_q.size(); k++) begin
            check($sformatf("t1_tidx%0d", k), 32'(feed_q[k]), 32'(k));
        end
        check("t1_btcnt", 32'(bt_cnt), 1);
        check_writes("t1", 5, 10'h010, 32'hA100_0000);
        check("t1_wcnt", 32'(o_word_cnt), 5);
        check("t1_err", 32'(o_err), 0);
        tick();
        check("t1_busy_idle", 32'(o_busy), 0);
        check("t1_done_low", 32'(o_done), 0);
        check("t1_done_cnt", 32'(done_cnt), 1);

        // 2: SRAM stall fills the buffer exactly, including full+pop in one cycle
        clear_mon();
        run_to_bt(5'd6, 10'h010, 3);
        send_bt(5, 1, 3, 32'hB200_0000);
        check("t2_drain_busy", 32'(o_busy), 1);
        wait_done(20, cyc);
        check("t2_done_cyc", 32'(cyc), 5);
        check("t2_we_at_done", 32'(o_sram_we), 0);
        check_writes("t2", 5, 10'h010, 32'hB200_0000);
        check("t2_wcnt", 32'(o_word_cnt), 5);
        check("t2_err", 32'(o_err), 0);
        tick();

        // 3: overflow drops the last two words
        clear_mon();
        run_to_bt(5'd3, 10'h020, 0);
        send_bt(6, 0, 6, 32'hC300_0000);
        check("t3_err_early", 32'(o_err), 1);
        check("t3_wcnt_early", 32'(o_word_cnt), 0);
        wait_done(20, cyc);
        check("t3_done_cyc", 32'(cyc), 5);
        check_writes("t3", 4, 10'h020, 32'hC300_0000);
        check("t3_wcnt", 32'(o_word_cnt), 4);
        check("t3_err", 32'(o_err), 1);
        tick();

        // 4: timeout, with a start pulse ignored while waiting
        clear_mon();
        start_job(5'd2, 10'h100);
        check("t4_err_cleared", 32'(o_err), 0);
        repeat (2) tick();
        check("t4_wait_fval", 32'(o_feed_valid), 0);
        check("t4_wait_busy", 32'(o_busy), 1);
        i_start = 1'b1;
        i_tlen = 5'd0;
        tick();
        i_start = 1'b0;
        check("t4_ign_done", 32'(o_done), 0);
        check("t4_ign_err", 32'(o_err), 0);
        wait_done(300, cyc);
        check("t4_done_cyc", 32'(cyc + 1), 255);
        check("t4_err", 32'(o_err), 1);
        check("t4_btcnt", 32'(bt_cnt), 0);
        check("t4_wcnt", 32'(o_word_cnt), 0);
        check("t4_nwr", 32'(wa_q.size()), 0);
        tick();
        check("t4_busy_idle", 32'(o_busy), 0);

        // 5: address wrap
        clear_mon();
        run_to_bt(5'd1, 10'h3FE, 1);
        send_bt(4, 0, 0, 32'hD400_0000);
        wait_done(20, cyc);
        check("t5_done_cyc", 32'(cyc), 2);
        check_writes("t5", 4, 10'h3FE, 32'hD400_0000);
        check("t5_wcnt", 32'(o_word_cnt), 4);
        check("t5_addr_next", 32'(o_sram_addr), 32'h002);
        check("t5_err", 32'(o_err), 0);
        tick();

        // 6: reset mid-BT, then zero-length job
        clear_mon();
        run_to_bt(5'd2, 10'h040, 0);
        i_sram_ready = 1'b0;
        i_bt_valid = 1'b1;
        i_bt_data = 32'hE500_0000;
        tick();
        tick();
        i_bt_valid = 1'b0;
        check("t6_we_pending", 32'(o_sram_we), 1);
        rst = 1'b1;
        #1;
        check_idle_outputs("t6rst");
        tick();
        rst = 1'b0;
        i_sram_ready = 1'b1;
        repeat (3) tick();
        check("t6_we_after", 32'(o_sram_we), 0);
        check("t6_busy_after", 32'(o_busy), 0);
        check("t6_no_done", 32'(done_cnt), 0);
        start_job(5'd0, 10'h080);
        check("t6_done", 32'(o_done), 1);
        check("t6_err", 32'(o_err), 1);
        check("t6_busy", 32'(o_busy), 1);
        tick();
        check("t6_busy_idle", 32'(o_busy), 0);
        check("t6_done_low", 32'(o_done), 0);
        check("t6_err_sticky", 32'(o_err), 1);
        check("t6_done_cnt", 32'(done_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
